sr_mdu_issue: RTL

//  CPU-side issue/stall controller for sr_mdu: accepts an MDU instruction from decode,

---
 rtl/sr_mdu_pkg.sv | 23 ++
 rtl/sr_mdu_issue_if.sv | 41 ++++
 rtl/sr_mdu_issue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sr_mdu_pkg.sv
// Shared types and widths for the sr_mdu issue/stall controller.
package sr_mdu_pkg;

  localparam int unsigned MDU_OP_W  = 3;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MUL = 3'b000
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WB
  } mdu_issue_state_t;

  // Only MUL is implemented by the attached sr_mdu today.
  function automatic logic op_supported(input logic [MDU_OP_W-1:0] op);
    return op == MDU_MUL;
  endfunction

endpackage

// File: rtl/sr_mdu_issue_if.sv
// Decode, writeback and sr_mdu handshake bundle for sr_mdu_issue.
interface sr_mdu_issue_if;
  import sr_mdu_pkg::*;

  logic                 req;
  logic [MDU_OP_W-1:0]  req_op;
  logic [XLEN-1:0]      req_srcA;
  logic [XLEN-1:0]      req_srcB;
  logic [REG_IDX_W-1:0] req_rd;
  logic                 flush;

  logic                 stall;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 err_illegal_op;
  logic                 err_timeout;

  logic [XLEN-1:0]      mdu_srcA;
  logic [XLEN-1:0]      mdu_srcB;
  logic [MDU_OP_W-1:0]  mdu_op;
  logic                 mdu_src_vld;
  logic                 mdu_src_clear;
  logic [XLEN-1:0]      mdu_result;
  logic                 mdu_result_vld;

  modport slave (
    input  req, req_op, req_srcA, req_srcB, req_rd, flush,
    input  mdu_result, mdu_result_vld,
    output stall, wb_we, wb_rd, wb_data, err_illegal_op, err_timeout,
    output mdu_srcA, mdu_srcB, mdu_op, mdu_src_vld, mdu_src_clear
  );

  modport master (
    output req, req_op, req_srcA, req_srcB, req_rd, flush,
    output mdu_result, mdu_result_vld,
    input  stall, wb_we, wb_rd, wb_data, err_illegal_op, err_timeout,
    input  mdu_srcA, mdu_srcB, mdu_op, mdu_src_vld, mdu_src_clear
  );

endinterface

// File: rtl/sr_mdu_issue.sv
// Issue/stall controller: freezes the core while sr_mdu computes, then emits
// a one-cycle register-file writeback. Handles flush, timeout and illegal ops.
module sr_mdu_issue #(
  parameter int unsigned MUL_LATENCY    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           reset_n,
  sr_mdu_issue_if.slave io_bus
);
  import sr_mdu_pkg::*;

  // A timeout shorter than the multiply path would abort every legal op.
  localparam int unsigned EFF_TIMEOUT = (TIMEOUT_CYCLES > MUL_LATENCY + 1) ?
                                        TIMEOUT_CYCLES : MUL_LATENCY + 2;
  localparam int unsigned CNT_W = $clog2(EFF_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_TIMEOUT - 1);

  mdu_issue_state_t r_state;
  mdu_issue_state_t w_state_nxt;

  logic [CNT_W-1:0]     r_wait_cnt;
  logic [XLEN-1:0]      r_srcA;
  logic [XLEN-1:0]      r_srcB;
  logic [MDU_OP_W-1:0]  r_op;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_wb_data;
  logic                 r_wb_we;
  logic                 r_src_vld;
  logic                 r_src_clear;
  logic                 r_err_illegal;
  logic                 r_err_timeout;

  logic w_op_legal;
  logic w_issue_cond;
  logic w_illegal_cond;
  logic w_cnt_last;
  logic w_stall;
  logic w_accept;
  logic w_illegal;
  logic w_capture;
  logic w_abort_flush;
  logic w_abort_timeout;

  assign w_op_legal     = op_supported(io_bus.req_op);
  assign w_issue_cond   = io_bus.req & w_op_legal & ~io_bus.flush;
  assign w_illegal_cond = io_bus.req & ~w_op_legal & ~io_bus.flush;
  assign w_cnt_last     = (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin : p_state
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_issue_cond) w_state_nxt = WAIT;
      WAIT: begin
        // Flush wins over a result arriving in the same cycle.
        if (io_bus.flush)               w_state_nxt = IDLE;
        else if (io_bus.mdu_result_vld) w_state_nxt = WB;
        else if (w_cnt_last)            w_state_nxt = IDLE;
      end
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin : p_outputs
    w_stall         = 1'b0;
    w_accept        = 1'b0;
    w_illegal       = 1'b0;
    w_capture       = 1'b0;
    w_abort_flush   = 1'b0;
    w_abort_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept  = w_issue_cond;
        w_illegal = w_illegal_cond;
        w_stall   = w_issue_cond;
      end
      WAIT: begin
        w_stall         = 1'b1;
        w_abort_flush   = io_bus.flush;
        w_capture       = ~io_bus.flush & io_bus.mdu_result_vld;
        w_abort_timeout = ~io_bus.flush & ~io_bus.mdu_result_vld & w_cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : p_wait_cnt
    if (!reset_n)              r_wait_cnt <= '0;
    else if (r_state == WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
    else                       r_wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin : p_operands
    if (!reset_n) begin
      r_srcA <= '0;
      r_srcB <= '0;
      r_op   <= '0;
      r_rd   <= '0;
    end else if (w_accept) begin
      r_srcA <= io_bus.req_srcA;
      r_srcB <= io_bus.req_srcB;
      r_op   <= io_bus.req_op;
      r_rd   <= io_bus.req_rd;
    end
  end

  always_ff @(posedge clk) begin : p_pulses
    if (!reset_n) begin
      r_wb_we       <= 1'b0;
      r_wb_data     <= '0;
      r_src_vld     <= 1'b0;
      r_src_clear   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      // x0 is hard-wired zero, so a result targeting it is dropped.
      r_wb_we       <= w_capture & (r_rd != '0);
      r_src_vld     <= w_accept;
      r_src_clear   <= w_abort_flush | w_abort_timeout;
      r_err_illegal <= w_illegal;
      r_err_timeout <= w_abort_timeout;
      if (w_capture) r_wb_data <= io_bus.mdu_result;
    end
  end

  assign io_bus.stall          = w_stall;
  assign io_bus.wb_we          = r_wb_we;
  assign io_bus.wb_rd          = r_rd;
  assign io_bus.wb_data        = r_wb_data;
  assign io_bus.err_illegal_op = r_err_illegal;
  assign io_bus.err_timeout    = r_err_timeout;
  assign io_bus.mdu_srcA       = r_srcA;
  assign io_bus.mdu_srcB       = r_srcB;
  assign io_bus.mdu_op         = r_op;
  assign io_bus.mdu_src_vld    = r_src_vld;
  assign io_bus.mdu_src_clear  = r_src_clear;

endmodule
